// File: rtl/vga_sync_gen.sv
// VGA pixel-timing generator: hpos/vpos counters, registered syncs and visible-area decodes.
// Optional 8-bit frame counter on port frame_cnt when VGA_SYNC_FRAME_CNT_EN is defined.
module vga_sync_gen #(
    parameter int unsigned H_DISPLAY = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_DISPLAY = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pix_en,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic       line_end,
    output logic       frame_start
`ifdef VGA_SYNC_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int unsigned CW      = 10;
    localparam int unsigned WW      = CW + 1;
    localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    // Window bounds carry one extra bit so an end bound of 1024 does not alias to 0.
    localparam logic [WW-1:0] H_VIS    = WW'(H_DISPLAY);
    localparam logic [WW-1:0] V_VIS    = WW'(V_DISPLAY);
    localparam logic [WW-1:0] HS_START = WW'(H_DISPLAY + H_FRONT);
    localparam logic [WW-1:0] HS_END   = WW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [WW-1:0] VS_START = WW'(V_DISPLAY + V_FRONT);
    localparam logic [WW-1:0] VS_END   = WW'(V_DISPLAY + V_FRONT + V_SYNC);

    if (H_TOTAL > 1024 || V_TOTAL > 1024 || H_TOTAL == 0 || V_TOTAL == 0) begin : g_bad_timing
        $error("vga_sync_gen: H_TOTAL and V_TOTAL must be in 1..1024");
    end

    logic [CW-1:0] h_q, h_d;
    logic [CW-1:0] v_q, v_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          h_wrap, v_wrap;

    // Next-state counters; syncs decode the next-state values to stay aligned with hpos/vpos.
    always_comb begin
        h_d    = h_q;
        v_d    = v_q;
        h_wrap = (h_q == H_LAST);
        v_wrap = (v_q == V_LAST);
        if (pix_en) begin
            if (h_wrap) begin
                h_d = '0;
                v_d = v_wrap ? '0 : v_q + CW'(1);
            end else begin
                h_d = h_q + CW'(1);
            end
        end
        hs_d = (({1'b0, h_d} >= HS_START) && ({1'b0, h_d} < HS_END)) ? SYNC_POL : ~SYNC_POL;
        vs_d = (({1'b0, v_d} >= VS_START) && ({1'b0, v_d} < VS_END)) ? SYNC_POL : ~SYNC_POL;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_q  <= '0;
            v_q  <= '0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] fcnt_q, fcnt_d;

    // Counts full-frame wraps; naturally rolls 255 -> 0.
    always_comb begin
        fcnt_d = fcnt_q;
        if (pix_en && h_wrap && v_wrap) begin
            fcnt_d = fcnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
        end
    end

    assign frame_cnt = fcnt_q;
`endif

    assign hpos        = h_q;
    assign vpos        = v_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign display_on  = ({1'b0, h_q} < H_VIS) && ({1'b0, v_q} < V_VIS);
    assign line_end    = h_wrap;
    assign frame_start = (h_q == '0) && (v_q == '0);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen: default horizontal timing, shortened vertical timing
// (6 visible + 2 front + 2 sync + 3 back = 13 lines) so full frames fit in a short run.
module tb_vga_sync_gen;

    localparam int H_TOT = 800;
    localparam int V_TOT = 13;
    localparam int V_DISP = 6;

    logic       clk;
    logic       rst_n;
    logic       pix_en;
    logic [9:0] hpos;
    logic [9:0] vpos;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic       line_end;
    logic       frame_start;
`ifdef VGA_SYNC_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int mis      = 0;
    int eh = 0, ev = 0;
    int n_hs, n_vs, n_disp, n_le, n_fs;

    vga_sync_gen #(
        .V_DISPLAY(6),
        .V_FRONT  (2),
        .V_SYNC   (2),
        .V_BACK   (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_en     (pix_en),
        .hpos       (hpos),
        .vpos       (vpos),
        .hsync      (hsync),
        .vsync      (vsync),
        .display_on (display_on),
        .line_end   (line_end),
        .frame_start(frame_start)
`ifdef VGA_SYNC_FRAME_CNT_EN
        ,
        .frame_cnt  (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock; advances the reference position and tallies per-cycle disagreements.
    task automatic tick();
        logic pe, rs;
        int   e_hs, e_vs, e_disp;
        pe = pix_en;
        rs = rst_n;
        @(posedge clk);
        #1;
        if (!rs) begin
            eh = 0;
            ev = 0;
        end else if (pe) begin
            if (eh == H_TOT - 1) begin
                eh = 0;
                ev = (ev == V_TOT - 1) ? 0 : ev + 1;
            end else begin
                eh = eh + 1;
            end
        end
        e_hs   = (eh >= 656 && eh < 752) ? 0 : 1;
        e_vs   = (ev >= 8 && ev < 10) ? 0 : 1;
        e_disp = (eh < 640 && ev < V_DISP) ? 1 : 0;
        if (hpos !== 10'(eh) || vpos !== 10'(ev) || hsync !== 1'(e_hs) || vsync !== 1'(e_vs)
            || display_on !== 1'(e_disp) || line_end !== (eh == H_TOT - 1)
            || frame_start !== (eh == 0 && ev == 0))
            mis++;
        if (hsync === 1'b0) n_hs++;
        if (vsync === 1'b0) n_vs++;
        if (display_on === 1'b1) n_disp++;
        if (line_end === 1'b1) n_le++;
        if (frame_start === 1'b1) n_fs++;
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(eh == h && ev == v) && n < 20000) begin
            tick();
            n++;
        end
        check("run_to_h", int'(hpos), h);
        check("run_to_v", int'(vpos), v);
    endtask

    initial begin
        rst_n  = 1'b0;
        pix_en = 1'b1;
        repeat (3) tick();
        check("rst_hpos", int'(hpos), 0);
        check("rst_vpos", int'(vpos), 0);
        check("rst_hsync", int'(hsync), 1);
        check("rst_vsync", int'(vsync), 1);
        check("rst_display_on", int'(display_on), 1);
        check("rst_frame_start", int'(frame_start), 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("rst_frame_cnt", int'(frame_cnt), 0);
`endif

        rst_n = 1'b1;
        tick();
        check("first_hpos", int'(hpos), 1);
        check("first_frame_start", int'(frame_start), 0);

        run_to(655, 0);
        check("hs_before", int'(hsync), 1);
        tick();
        check("hs_first", int'(hsync), 0);
        run_to(751, 0);
        check("hs_last", int'(hsync), 0);
        tick();
        check("hs_after", int'(hsync), 1);
        run_to(799, 0);
        check("line_end_799", int'(line_end), 1);
        tick();
        check("wrap_hpos", int'(hpos), 0);
        check("wrap_vpos", int'(vpos), 1);
        check("wrap_line_end", int'(line_end), 0);

        run_to(0, 0);
        check("frame0_start", int'(frame_start), 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("frame_cnt_1", int'(frame_cnt), 1);
`endif

        n_hs = 0; n_vs = 0; n_disp = 0; n_le = 0; n_fs = 0;
        repeat (H_TOT * V_TOT) tick();
        check("frame_hs_cycles", n_hs, 96 * V_TOT);
        check("frame_vs_cycles", n_vs, 1600);
        check("frame_disp_cycles", n_disp, 640 * V_DISP);
        check("frame_line_ends", n_le, V_TOT);
        check("frame_starts", n_fs, 1);
        check("frame1_hpos", int'(hpos), 0);
        check("frame1_vpos", int'(vpos), 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("frame_cnt_2", int'(frame_cnt), 2);
`endif

        run_to(799, 7);
        check("vs_before", int'(vsync), 1);
        tick();
        check("vs_first", int'(vsync), 0);
        run_to(799, 9);
        check("vs_last", int'(vsync), 0);
        tick();
        check("vs_after", int'(vsync), 1);
        check("disp_off_v10", int'(display_on), 0);
        run_to(0, 0);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("frame_cnt_3", int'(frame_cnt), 3);
`endif

        run_to(700, 0);
        check("gate_hs_in", int'(hsync), 0);
        pix_en = 1'b0;
        repeat (3) tick();
        check("gate_hold_hpos", int'(hpos), 700);
        check("gate_hold_hsync", int'(hsync), 0);
        pix_en = 1'b1;
        tick();
        check("gate_step1", int'(hpos), 701);
        pix_en = 1'b0;
        tick();
        check("gate_hold2", int'(hpos), 701);
        pix_en = 1'b1;
        tick();
        check("gate_step2", int'(hpos), 702);
        run_to(799, 0);
        pix_en = 1'b0;
        repeat (2) tick();
        check("gate_line_end_level", int'(line_end), 1);
        check("gate_line_end_hpos", int'(hpos), 799);
        pix_en = 1'b1;
        tick();
        check("gate_resume_v", int'(vpos), 1);

        run_to(700, 9);
        check("mid_hs_active", int'(hsync), 0);
        check("mid_vs_active", int'(vsync), 0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_hpos", int'(hpos), 0);
        check("mid_rst_vpos", int'(vpos), 0);
        check("mid_rst_hsync", int'(hsync), 1);
        check("mid_rst_vsync", int'(vsync), 1);
`ifdef VGA_SYNC_FRAME_CNT_EN
        check("mid_rst_frame_cnt", int'(frame_cnt), 0);
`endif
        rst_n = 1'b1;
        tick();
        check("post_rst_hpos", int'(hpos), 1);

        check("model_track", mis, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
